mem_access: RTL

MEM-stage data-memory access unit for the five-stage MIPS pipeline. Takes the MEM-stage opcode, effective address and store data, runs a request/acknowledge transaction on the data-memory port, and stalls the pipeline until the transaction completes. It produces the raw, word-aligned `readdataM`, which is registered into `readdataW` for the downstream load-data selection in writeback. It also generates byte strobes and lane-replicated store data for SB/SH/SW, and optionally detects misaligned-address exceptions.

---
 rtl/mem_access_pkg.sv | 28 ++
 rtl/mem_access_store_fmt.sv | 47 ++++
 rtl/mem_access.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - opcodes, FSM states and opcode-class helpers for mem_access
package mem_access_pkg;

  localparam logic [5:0] op_LB  = 6'h20;
  localparam logic [5:0] op_LH  = 6'h21;
  localparam logic [5:0] op_LW  = 6'h23;
  localparam logic [5:0] op_LBU = 6'h24;
  localparam logic [5:0] op_LHU = 6'h25;
  localparam logic [5:0] op_SB  = 6'h28;
  localparam logic [5:0] op_SH  = 6'h29;
  localparam logic [5:0] op_SW  = 6'h2B;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == op_LB) || (op == op_LBU) || (op == op_LH) ||
           (op == op_LHU) || (op == op_LW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == op_SB) || (op == op_SH) || (op == op_SW);
  endfunction

endpackage

// File: rtl/mem_access_store_fmt.sv
// rtl/mem_access_store_fmt.sv - store strobe/lane formatting and alignment check (MEM_ADDR_EXC_EN)
module store_fmt
  import mem_access_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  output logic        wr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        addr_err
);

  // Replicate store data across lanes and pick strobes; loads leave the bus write-idle
  always_comb begin
    wr       = 1'b0;
    wstrb    = 4'b0000;
    wdata    = 32'h0;
    addr_err = 1'b0;
    case (op)
      op_SB: begin
        wr    = 1'b1;
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{wd[7:0]}};
      end
      op_SH: begin
        wr    = 1'b1;
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
      end
      op_SW: begin
        wr    = 1'b1;
        wstrb = 4'b1111;
        wdata = wd;
      end
      default: ;
    endcase
`ifdef MEM_ADDR_EXC_EN
    case (op)
      op_LH, op_LHU, op_SH: addr_err = addr_lo[0];
      op_LW, op_SW:         addr_err = |addr_lo;
      default:              addr_err = 1'b0;
    endcase
`endif
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage data-memory req/ack unit with stall (MEM_ADDR_EXC_EN enables address exceptions)
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [5:0]        opM,
  input  logic              memenM,
  input  logic              flushM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [31:0]       writedataM,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_ack,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       readdataM,
  output logic              stallM,
  output logic              adelM,
  output logic              adesM,
  output logic [ADDR_W-1:0] badvaddrM
);

  mem_state_e        state_q, state_d;
  logic              wr_q, wr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              load_q, load_d;
  logic              flushed_q, flushed_d;

  logic              fmt_wr;
  logic [3:0]        fmt_wstrb;
  logic [31:0]       fmt_wdata;
  logic              addr_err;
  logic              trigger;

  store_fmt u_store_fmt (
    .op       (opM),
    .addr_lo  (aluoutM[1:0]),
    .wd       (writedataM),
    .wr       (fmt_wr),
    .wstrb    (fmt_wstrb),
    .wdata    (fmt_wdata),
    .addr_err (addr_err)
  );

  assign trigger = memenM & ~flushM & ~addr_err;

  // Next-state and stall/request decode; stall depends on data_ack only via the state register
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    load_d    = load_q;
    flushed_d = flushed_q;
    stallM    = 1'b0;
    data_req  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        stallM = trigger;
        if (trigger) begin
          wr_d      = fmt_wr;
          wstrb_d   = fmt_wstrb;
          addr_d    = {aluoutM[ADDR_W-1:2], 2'b00};
          wdata_d   = fmt_wdata;
          load_d    = is_load(opM);
          flushed_d = 1'b0;
          state_d   = MEM_REQ;
        end
      end
      MEM_REQ: begin
        data_req = 1'b1;
        stallM   = 1'b1;
        if (flushM) flushed_d = 1'b1;
        if (data_ack) begin
          // A killed instruction still finishes its bus beat but must not touch readdataM
          if (load_q && !flushM && !flushed_q) rdata_d = data_rdata;
          state_d = (flushM || flushed_q) ? MEM_IDLE : MEM_DONE;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // State and bus-latch registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= MEM_IDLE;
      wr_q      <= 1'b0;
      wstrb_q   <= 4'b0000;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      load_q    <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      load_q    <= load_d;
      flushed_q <= flushed_d;
    end
  end

  assign data_wr    = wr_q;
  assign data_wstrb = wstrb_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign readdataM  = rdata_q;

`ifdef MEM_ADDR_EXC_EN
  logic exc_valid;
  assign exc_valid = (state_q == MEM_IDLE) & memenM & ~flushM & addr_err;
  assign adelM     = exc_valid & is_load(opM);
  assign adesM     = exc_valid & is_store(opM);
  assign badvaddrM = exc_valid ? aluoutM : '0;
`else
  assign adelM     = 1'b0;
  assign adesM     = 1'b0;
  assign badvaddrM = '0;
`endif

endmodule
